// File: rtl/memory_access.sv
// Load/store unit front end: decodes one RV32I memory operation, issues a single
// data-memory request, waits for grant/read data with a timeout, and reports completion.
module memory_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_mem_rd,
  output logic        out_fault
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [1:0]  state_q, state_d;
  logic [6:0]  opcode_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, data_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rd_q, rd_d;
  logic        fault_q, fault_d;

  logic accept;
  logic in_is_load, in_is_store, in_legal, in_misaligned;
  logic timeout;

  assign accept = in_valid & in_ready;

  assign in_is_load  = (in_opcode == OP_LOAD);
  assign in_is_store = (in_opcode == OP_STORE);

  always_comb begin
    in_legal = 1'b0;
    if (in_is_load) begin
      in_legal = (in_funct3 == 3'd0) || (in_funct3 == 3'd1) || (in_funct3 == 3'd2) ||
                 (in_funct3 == 3'd4) || (in_funct3 == 3'd5);
    end else if (in_is_store) begin
      in_legal = (in_funct3 <= 3'd2);
    end
  end

  assign in_misaligned = ((in_funct3[1:0] == 2'd1) && in_addr[0]) ||
                         ((in_funct3[1:0] == 2'd2) && (in_addr[1:0] != 2'b00));

  // Counter already holds the cycles spent before this one, so the last allowed cycle is T-1.
  assign timeout = 32'(cnt_q) >= (TIMEOUT_CYCLES - 32'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = 8'd0;
          rd_d    = 32'd0;
          fault_d = 1'b0;
          if (!in_is_load && !in_is_store) begin
            state_d = RESP;
          end else if (!in_legal || in_misaligned) begin
            fault_d = 1'b1;
            state_d = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_gnt) begin
          state_d = (opcode_q == OP_STORE) ? RESP : WAIT;
        end else if (timeout) begin
          fault_d = 1'b1;
          rd_d    = 32'd0;
          state_d = RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rvalid) begin
          rd_d    = mem_rdata >> {addr_q[1:0], 3'b000};
          state_d = RESP;
        end else if (timeout) begin
          fault_d = 1'b1;
          rd_d    = 32'd0;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      opcode_q <= 7'd0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      cnt_q    <= 8'd0;
      rd_q     <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      fault_q <= fault_d;
      if (accept) begin
        opcode_q <= in_opcode;
        funct3_q <= in_funct3;
        addr_q   <= in_addr;
        data_q   <= in_store_data;
      end
    end
  end

  assign in_ready   = (state_q == IDLE) & ~rst;
  assign mem_req    = (state_q == REQ);
  assign out_valid  = (state_q == RESP);
  assign out_mem_rd = rd_q;
  assign out_fault  = fault_q;

  // Bus fields are driven only while requesting, otherwise they idle at zero.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_be    = 4'd0;
    mem_wdata = 32'd0;
    if (mem_req) begin
      mem_we   = (opcode_q == OP_STORE);
      mem_addr = {addr_q[31:2], 2'b00};
      unique case (funct3_q[1:0])
        2'd0: begin
          mem_be    = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{data_q[7:0]}};
        end
        2'd1: begin
          mem_be    = 4'b0011 << addr_q[1:0];
          mem_wdata = {2{data_q[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = data_q;
        end
      endcase
    end
  end

endmodule
